toggle_leds_engine: RTL and testbench

- Downstream consumer of the toggle_leds AXI4-Lite slave register file.
- Takes the four slave registers (ctrl, period, mask, count) plus a write strobe and drives the board LEDs through a prescaled step engine.
- Returns status (busy, done, step count) for readback muxing.
- Sits between the AXI slave register bank and the top-level LED pins.

---
 rtl/toggle_leds_engine.sv | 157 +++++++++++++++
 tb/tb_toggle_leds_engine.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/toggle_leds_engine.sv
// toggle_leds_engine: prescaled LED step engine driven by the toggle_leds
// AXI4-Lite register bank. Turns ctrl/period/mask/count into LED patterns
// (toggle, chase-left, chase-right, static) and reports busy/done/step count.
module toggle_leds_engine #(
  parameter int unsigned NUM_LEDS           = 4,
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned MIN_PERIOD         = 2
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] ctrl_reg,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] period_reg,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] mask_reg,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] count_reg,
  input  logic                          cfg_update,
  output logic [NUM_LEDS-1:0]           leds,
  output logic                          busy,
  output logic                          done,
  output logic [C_S_AXI_DATA_WIDTH-1:0] step_cnt
);

  localparam int unsigned W = C_S_AXI_DATA_WIDTH;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [1:0] MODE_TOGGLE = 2'b00;
  localparam logic [1:0] MODE_LEFT   = 2'b01;
  localparam logic [1:0] MODE_RIGHT  = 2'b10;
  localparam logic [1:0] MODE_STATIC = 2'b11;

  logic [1:0]          state_q, state_d;
  logic [NUM_LEDS-1:0] leds_q, leds_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [W-1:0]        step_q, step_d;
  logic [W-1:0]        presc_q, presc_d;

  logic                enable;
  logic [1:0]          mode;
  logic                oneshot;
  logic [NUM_LEDS-1:0] mask_w;
  logic [W-1:0]        period_eff;
  logic                tick;
  logic [W-1:0]        step_next;
  logic [NUM_LEDS-1:0] leds_step;
  logic [NUM_LEDS-1:0] leds_load;

  assign enable     = ctrl_reg[0];
  assign mode       = ctrl_reg[2:1];
  assign oneshot    = ctrl_reg[3];
  assign mask_w     = mask_reg[NUM_LEDS-1:0];
  assign period_eff = (period_reg < W'(MIN_PERIOD)) ? W'(MIN_PERIOD) : period_reg;
  // ">=" rather than "==" so a period shrunk below the running count ticks at once
  assign tick       = (presc_q >= (period_eff - W'(1)));
  assign step_next  = step_q + W'(1);

  // Next LED pattern for one step in the current mode
  always_comb begin
    leds_step = leds_q;
    case (mode)
      MODE_TOGGLE: leds_step = leds_q ^ mask_w;
      MODE_LEFT:   leds_step = {leds_q[NUM_LEDS-2:0], leds_q[NUM_LEDS-1]};
      MODE_RIGHT:  leds_step = {leds_q[0], leds_q[NUM_LEDS-1:1]};
      MODE_STATIC: leds_step = leds_q;
      default:     leds_step = leds_q;
    endcase
  end

  // Pattern loaded on restart; chase modes need a non-zero seed
  always_comb begin
    leds_load = mask_w;
    if (((mode == MODE_LEFT) || (mode == MODE_RIGHT)) && (mask_w == '0)) begin
      leds_load = NUM_LEDS'(1);
    end
  end

  // Engine FSM and datapath next-state
  always_comb begin
    state_d = state_q;
    leds_d  = leds_q;
    step_d  = step_q;
    presc_d = presc_q;
    case (state_q)
      ST_IDLE: begin
        leds_d  = '0;
        presc_d = '0;
        if (enable) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        leds_d  = leds_load;
        presc_d = '0;
        step_d  = '0;
        state_d = (oneshot && (count_reg == '0)) ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        if (!enable) begin
          state_d = ST_IDLE;
          leds_d  = '0;
          presc_d = '0;
        end else if (cfg_update) begin
          state_d = ST_LOAD;
        end else if (tick) begin
          presc_d = '0;
          leds_d  = leds_step;
          step_d  = step_next;
          if (oneshot && (step_next == count_reg)) begin
            state_d = ST_DONE;
          end
        end else begin
          presc_d = presc_q + W'(1);
        end
      end
      ST_DONE: begin
        if (!enable) begin
          state_d = ST_IDLE;
          leds_d  = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        leds_d  = '0;
      end
    endcase
    busy_d = (state_d == ST_LOAD) || (state_d == ST_RUN);
    done_d = (state_d == ST_DONE) && (state_q != ST_DONE);
  end

  // State and output registers
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q <= ST_IDLE;
      leds_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      step_q  <= '0;
      presc_q <= '0;
    end else begin
      state_q <= state_d;
      leds_q  <= leds_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      step_q  <= step_d;
      presc_q <= presc_d;
    end
  end

  assign leds     = leds_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign step_cnt = step_q;

endmodule

// File: tb/tb_toggle_leds_engine.sv
// Bench for toggle_leds_engine: per-cycle vector table checked through a
// scoreboard queue, plus hand-written reset/restart sequences.
module tb_toggle_leds_engine;

  logic        ACLK;
  logic        ARESET;
  logic [31:0] ctrl_reg;
  logic [31:0] period_reg;
  logic [31:0] mask_reg;
  logic [31:0] count_reg;
  logic        cfg_update;
  logic [3:0]  leds;
  logic        busy;
  logic        done;
  logic [31:0] step_cnt;

  toggle_leds_engine #(
    .NUM_LEDS(4),
    .C_S_AXI_DATA_WIDTH(32),
    .MIN_PERIOD(2)
  ) dut (
    .ACLK(ACLK),
    .ARESET(ARESET),
    .ctrl_reg(ctrl_reg),
    .period_reg(period_reg),
    .mask_reg(mask_reg),
    .count_reg(count_reg),
    .cfg_update(cfg_update),
    .leds(leds),
    .busy(busy),
    .done(done),
    .step_cnt(step_cnt)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [31:0] ctrl;
    logic [31:0] period;
    logic [31:0] mask;
    logic [31:0] count;
    logic        cfg;
    logic [3:0]  e_leds;
    logic        e_busy;
    logic        e_done;
    logic [31:0] e_step;
  } vec_t;

  typedef struct {
    int          idx;
    logic [3:0]  leds;
    logic        busy;
    logic        done;
    logic [31:0] step;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   total;
  int   bad;

  function automatic void add(input logic [31:0] c, input logic [31:0] p,
                              input logic [31:0] m, input logic [31:0] n,
                              input logic cfg, input logic [3:0] el,
                              input logic eb, input logic ed, input logic [31:0] es);
    vec_t v;
    v.ctrl = c; v.period = p; v.mask = m; v.count = n; v.cfg = cfg;
    v.e_leds = el; v.e_busy = eb; v.e_done = ed; v.e_step = es;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge: drive one row, let one posedge pass, compare at the next negedge
  task automatic apply(input int idx, input vec_t v);
    exp_t e;
    exp_t g;
    ctrl_reg   = v.ctrl;
    period_reg = v.period;
    mask_reg   = v.mask;
    count_reg  = v.count;
    cfg_update = v.cfg;
    e.idx = idx; e.leds = v.e_leds; e.busy = v.e_busy; e.done = v.e_done; e.step = v.e_step;
    sb.push_back(e);
    @(posedge ACLK);
    @(negedge ACLK);
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL row%0d: scoreboard empty", idx);
    end else begin
      g = sb.pop_front();
      chk($sformatf("row%0d leds", g.idx), 32'(leds), 32'(g.leds));
      chk($sformatf("row%0d busy", g.idx), 32'(busy), 32'(g.busy));
      chk($sformatf("row%0d done", g.idx), 32'(done), 32'(g.done));
      chk($sformatf("row%0d step", g.idx), step_cnt, g.step);
    end
  endtask

  task automatic cyc();
    @(posedge ACLK);
    @(negedge ACLK);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    ARESET     = 1'b1;
    ctrl_reg   = '0;
    period_reg = '0;
    mask_reg   = '0;
    count_reg  = '0;
    cfg_update = 1'b0;

    // ctrl, period, mask, count, cfg | leds, busy, done, step
    // toggle, P=4, mask 5
    add('h1, 4, 'h5, 0, 1, 'h0, 1, 0, 0);
    add('h1, 4, 'h5, 0, 0, 'h5, 1, 0, 0);
    add('h1, 4, 'h5, 0, 0, 'h5, 1, 0, 0);
    add('h1, 4, 'h5, 0, 0, 'h5, 1, 0, 0);
    add('h1, 4, 'h5, 0, 0, 'h5, 1, 0, 0);
    add('h1, 4, 'h5, 0, 0, 'h0, 1, 0, 1);
    add('h1, 4, 'h5, 0, 0, 'h0, 1, 0, 1);
    add('h1, 4, 'h5, 0, 0, 'h0, 1, 0, 1);
    add('h1, 4, 'h5, 0, 0, 'h0, 1, 0, 1);
    add('h1, 4, 'h5, 0, 0, 'h5, 1, 0, 2);
    // enable drop together with cfg_update: idle wins
    add('h0, 4, 'h5, 0, 1, 'h0, 0, 0, 2);
    add('h0, 4, 'h5, 0, 0, 'h0, 0, 0, 2);
    // chase-left, mask 0 seeds 1, period 1 clamps to 2
    add('h3, 1, 'h0, 0, 1, 'h0, 1, 0, 2);
    add('h3, 1, 'h0, 0, 0, 'h1, 1, 0, 0);
    add('h3, 1, 'h0, 0, 0, 'h1, 1, 0, 0);
    add('h3, 1, 'h0, 0, 0, 'h2, 1, 0, 1);
    add('h3, 1, 'h0, 0, 0, 'h2, 1, 0, 1);
    add('h3, 1, 'h0, 0, 0, 'h4, 1, 0, 2);
    add('h3, 1, 'h0, 0, 0, 'h4, 1, 0, 2);
    add('h3, 1, 'h0, 0, 0, 'h8, 1, 0, 3);
    add('h3, 1, 'h0, 0, 0, 'h8, 1, 0, 3);
    add('h3, 1, 'h0, 0, 0, 'h1, 1, 0, 4);
    add('h3, 1, 'h0, 0, 0, 'h1, 1, 0, 4);
    // cfg_update on a tick cycle: restart, no step applied
    add('h3, 1, 'h6, 0, 1, 'h1, 1, 0, 4);
    add('h3, 1, 'h6, 0, 0, 'h6, 1, 0, 0);
    add('h3, 1, 'h6, 0, 0, 'h6, 1, 0, 0);
    add('h3, 1, 'h6, 0, 0, 'hC, 1, 0, 1);
    add('h0, 1, 'h6, 0, 0, 'h0, 0, 0, 1);
    // oneshot chase-left, count 3, period 3
    add('hB, 3, 'h1, 3, 1, 'h0, 1, 0, 1);
    add('hB, 3, 'h1, 3, 0, 'h1, 1, 0, 0);
    add('hB, 3, 'h1, 3, 0, 'h1, 1, 0, 0);
    add('hB, 3, 'h1, 3, 0, 'h1, 1, 0, 0);
    add('hB, 3, 'h1, 3, 0, 'h2, 1, 0, 1);
    add('hB, 3, 'h1, 3, 0, 'h2, 1, 0, 1);
    add('hB, 3, 'h1, 3, 0, 'h2, 1, 0, 1);
    add('hB, 3, 'h1, 3, 0, 'h4, 1, 0, 2);
    add('hB, 3, 'h1, 3, 0, 'h4, 1, 0, 2);
    add('hB, 3, 'h1, 3, 0, 'h4, 1, 0, 2);
    add('hB, 3, 'h1, 3, 0, 'h8, 0, 1, 3);
    add('hB, 3, 'h1, 3, 0, 'h8, 0, 0, 3);
    add('hB, 3, 'h1, 3, 1, 'h8, 0, 0, 3);
    add('h0, 3, 'h1, 3, 0, 'h0, 0, 0, 3);
    // oneshot with count 0: straight from LOAD to DONE
    add('h9, 4, 'h5, 0, 1, 'h0, 1, 0, 3);
    add('h9, 4, 'h5, 0, 0, 'h5, 0, 1, 0);
    add('h9, 4, 'h5, 0, 0, 'h5, 0, 0, 0);
    add('h0, 4, 'h5, 0, 0, 'h0, 0, 0, 0);
    // period shrinks below the running prescaler: immediate tick
    add('h1, 8, 'hF, 0, 1, 'h0, 1, 0, 0);
    add('h1, 8, 'hF, 0, 0, 'hF, 1, 0, 0);
    for (int i = 0; i < 6; i++) add('h1, 8, 'hF, 0, 0, 'hF, 1, 0, 0);
    add('h1, 3, 'hF, 0, 0, 'h0, 1, 0, 1);
    add('h1, 3, 'hF, 0, 0, 'h0, 1, 0, 1);
    add('h1, 3, 'hF, 0, 0, 'h0, 1, 0, 1);
    add('h1, 3, 'hF, 0, 0, 'hF, 1, 0, 2);
    add('h0, 3, 'hF, 0, 0, 'h0, 0, 0, 2);

    // reset values
    @(negedge ACLK);
    @(negedge ACLK);
    chk("rst leds", 32'(leds), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst done", 32'(done), 0);
    chk("rst step", step_cnt, 0);
    ARESET = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      apply(i, vecs[i]);
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
    end

    // async reset mid-RUN: chase-left from seed 8, period 2
    ctrl_reg = 32'h3; period_reg = 32'd2; mask_reg = 32'h8; count_reg = '0; cfg_update = 1'b1;
    cyc();
    cfg_update = 1'b0;
    chk("seq6 load busy", 32'(busy), 1);
    cyc();
    chk("seq6 seed", 32'(leds), 32'h8);
    repeat (14) cyc();
    chk("seq6 pre leds", 32'(leds), 32'h4);
    chk("seq6 pre step", step_cnt, 7);
    #1 ARESET = 1'b1;
    #1;
    chk("seq6 async leds", 32'(leds), 0);
    chk("seq6 async busy", 32'(busy), 0);
    chk("seq6 async done", 32'(done), 0);
    chk("seq6 async step", step_cnt, 0);
    cyc();
    chk("seq6 held leds", 32'(leds), 0);
    ARESET = 1'b0;
    chk("seq6 rel busy", 32'(busy), 0);
    cyc();
    chk("seq6 reload busy", 32'(busy), 1);
    chk("seq6 reload leds", 32'(leds), 0);
    cyc();
    chk("seq6 run leds", 32'(leds), 32'h8);
    chk("seq6 run step", step_cnt, 0);
    chk("seq6 run busy", 32'(busy), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
